// File: rtl/memory_mapper_pkg.sv
// Shared types and constants for the MSX memory mapper.
// Optional readback is controlled by MEMORY_MAPPER_READBACK_EN (see memory_mapper_core).
package memory_mapper_pkg;

  localparam int MAPPER_PAGES = 4;

  typedef enum logic [1:0] {
    MAPPER_IDLE    = 2'd0,
    MAPPER_ACK     = 2'd1,
    MAPPER_RDATA   = 2'd2,
    MAPPER_RELEASE = 2'd3
  } mapper_state_t;

  // Power-on layout: page 0 -> segment 3 ... page 3 -> segment 0.
  localparam logic [7:0] MAPPER_INIT_SEG [0:MAPPER_PAGES-1] = '{8'h03, 8'h02, 8'h01, 8'h00};

  // Unimplemented upper bits read as 1 so software RAM-size probes work.
  function automatic logic [7:0] readback_byte(input logic [7:0] seg, input int seg_bits);
    logic [7:0] hi;
    hi = 8'hFF << seg_bits;
    return hi | seg;
  endfunction

endpackage

// File: rtl/memory_mapper_regs.sv
// Four-entry segment register file: one write port, an I/O readback port
// and a page-lookup port, both read combinationally.
module memory_mapper_regs
  import memory_mapper_pkg::*;
#(
  parameter int SEG_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we,
  input  logic [1:0]          wpage,
  input  logic [SEG_BITS-1:0] wdata,
  input  logic [1:0]          io_page,
  output logic [SEG_BITS-1:0] io_seg,
  input  logic [1:0]          lookup_page,
  output logic [SEG_BITS-1:0] lookup_seg
);

  logic [SEG_BITS-1:0] seg_q [MAPPER_PAGES];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < MAPPER_PAGES; i++) begin
        seg_q[i] <= MAPPER_INIT_SEG[i][SEG_BITS-1:0];
      end
    end else if (we) begin
      seg_q[wpage] <= wdata;
    end
  end

  assign io_seg     = seg_q[io_page];
  assign lookup_seg = seg_q[lookup_page];

endmodule

// File: rtl/memory_mapper_core.sv
// MSX memory mapper: I/O port decode, transaction FSM and registered page lookup.
// Define MEMORY_MAPPER_READBACK_EN to enable register readback; otherwise write-only.
//
// Handshake: the requester raises bus_io_req and holds it until it sees bus_ack
// (one cycle). A read then gets one bus_rdata_en cycle carrying bus_rdata. The
// FSM waits for bus_io_req low before accepting again, so a held request is
// served once; after reset a request must also be seen low before acceptance.
module memory_mapper_core
  import memory_mapper_pkg::*;
#(
  parameter int         SEG_BITS = 8,
  parameter logic [7:0] IO_BASE  = 8'hFC
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   bus_io_req,
  output logic                   bus_ack,
  input  logic                   bus_wrt,
  input  logic [15:0]            bus_address,
  input  logic [7:0]             bus_wdata,
  output logic [7:0]             bus_rdata,
  output logic                   bus_rdata_en,
  output logic [7:0]             mapper_segment,
  output logic [SEG_BITS+13:0]   mapper_address,
  output mapper_state_t          state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACK     = 2'd1;
  localparam logic [1:0] ST_RDATA   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                armed_q;
  logic [1:0]          page_q;
  logic                wrt_q;
  logic [SEG_BITS-1:0] wdata_q;
  logic                hit, accept, we;
  logic [SEG_BITS-1:0] io_seg, lookup_seg, lookup_next, lookup_q;
  logic [13:0]         offset_q;

  assign hit    = (bus_address[7:2] == IO_BASE[7:2]);
  assign accept = bus_io_req && hit && armed_q;
  assign we     = (state_q == ST_ACK) && wrt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_ACK;
`ifdef MEMORY_MAPPER_READBACK_EN
      ST_ACK:     state_d = wrt_q ? ST_RELEASE : ST_RDATA;
`else
      ST_ACK:     state_d = ST_RELEASE;
`endif
      ST_RDATA:   state_d = ST_RELEASE;
      ST_RELEASE: if (!bus_io_req) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // armed_q blocks a request that was already high across reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
      page_q  <= 2'd0;
      wrt_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_q | ~bus_io_req;
      if (state_q == ST_IDLE && accept) begin
        page_q  <= bus_address[1:0];
        wrt_q   <= bus_wrt;
        wdata_q <= bus_wdata[SEG_BITS-1:0];
      end
    end
  end

  memory_mapper_regs #(
    .SEG_BITS (SEG_BITS)
  ) u_regs (
    .clk         (clk),
    .reset_n     (reset_n),
    .we          (we),
    .wpage       (page_q),
    .wdata       (wdata_q),
    .io_page     (page_q),
    .io_seg      (io_seg),
    .lookup_page (bus_address[15:14]),
    .lookup_seg  (lookup_seg)
  );

  // Forward the ACK-cycle write so the lookup shows it on the following cycle.
  assign lookup_next = (we && page_q == bus_address[15:14]) ? wdata_q : lookup_seg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lookup_q <= '0;
      offset_q <= 14'd0;
    end else begin
      lookup_q <= lookup_next;
      offset_q <= bus_address[13:0];
    end
  end

  assign mapper_segment = 8'(lookup_q);
  assign mapper_address = {lookup_q, offset_q};
  assign bus_ack        = (state_q == ST_ACK);
  assign state          = mapper_state_t'(state_q);

`ifdef MEMORY_MAPPER_READBACK_EN
  logic unused_bits;
  assign unused_bits  = ^bus_wdata;
  assign bus_rdata_en = (state_q == ST_RDATA);
  assign bus_rdata    = bus_rdata_en ? readback_byte(8'(io_seg), SEG_BITS) : 8'h00;
`else
  logic unused_bits;
  assign unused_bits  = ^{bus_wdata, io_seg};
  assign bus_rdata_en = 1'b0;
  assign bus_rdata    = 8'h00;
`endif

endmodule

// File: tb/tb_memory_mapper_core.sv
// Self-checking bench for memory_mapper_core: an 8-bit and a 5-bit instance share one bus.
module tb_memory_mapper_core;
  import memory_mapper_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_io_req = 1'b0;
  logic        bus_wrt = 1'b0;
  logic [15:0] bus_address = 16'h0000;
  logic [7:0]  bus_wdata = 8'h00;

  logic          ack8, en8, ack5, en5;
  logic [7:0]    rdata8, rdata5, seg8, seg5;
  logic [21:0]   addr8;
  logic [18:0]   addr5;
  mapper_state_t state8, state5;

  int checks = 0;
  int errors = 0;

  logic [7:0] m8 [4];
  logic [7:0] m5 [4];

  memory_mapper_core #(.SEG_BITS(8), .IO_BASE(8'hFC)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus_io_req(bus_io_req), .bus_ack(ack8),
    .bus_wrt(bus_wrt), .bus_address(bus_address), .bus_wdata(bus_wdata),
    .bus_rdata(rdata8), .bus_rdata_en(en8), .mapper_segment(seg8),
    .mapper_address(addr8), .state(state8));

  memory_mapper_core #(.SEG_BITS(5), .IO_BASE(8'hFC)) dut5 (
    .clk(clk), .reset_n(reset_n), .bus_io_req(bus_io_req), .bus_ack(ack5),
    .bus_wrt(bus_wrt), .bus_address(bus_address), .bus_wdata(bus_wdata),
    .bus_rdata(rdata5), .bus_rdata_en(en5), .mapper_segment(seg5),
    .mapper_address(addr5), .state(state5));

  always #5 clk = ~clk;

  // Reference model: mapper registers as plain arrays.
  function automatic void model_reset();
    m8 = '{8'h03, 8'h02, 8'h01, 8'h00};
    m5 = '{8'h03, 8'h02, 8'h01, 8'h00};
  endfunction

  function automatic void model_write(input int page, input logic [7:0] data);
    m8[page] = data;
    m5[page] = data & 8'h1F;
  endfunction

  // Drive one request and observe 12 cycles; cycle 1 is the cycle after the sampling edge.
  task automatic io_access(input logic [15:0] addr, input logic wrt, input logic [7:0] wd,
                           input int hold, output int ack_cnt, output int ack_at,
                           output int en_cnt, output int en_at, output logic [7:0] rd8,
                           output logic [7:0] rd5, output int ack5_cnt,
                           output logic [7:0] seg_after, output int rd_bad);
    ack_cnt = 0; ack_at = -1; en_cnt = 0; en_at = -1; rd8 = 8'h00; rd5 = 8'h00;
    ack5_cnt = 0; seg_after = 8'h00; rd_bad = 0;
    @(negedge clk);
    bus_address = addr; bus_wrt = wrt; bus_wdata = wd; bus_io_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack8) begin ack_cnt++; if (ack_at < 0) ack_at = c; end
      if (ack5) ack5_cnt++;
      if (en8) begin en_cnt++; if (en_at < 0) en_at = c; rd8 = rdata8; end
      if (en5) rd5 = rdata5;
      if ((!en8 && rdata8 != 8'h00) || (!en5 && rdata5 != 8'h00)) rd_bad++;
      if (c == 2) seg_after = seg8;
      if (bus_io_req && c >= hold && (ack_cnt > 0 || c >= 4)) bus_io_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bus_io_req = 1'b0; bus_address = 16'h0000;
    repeat (3) @(negedge clk);
    checks++; if (seg8 !== 8'h00 || seg5 !== 8'h00) begin errors++; $display("FAIL reset_segment got %h/%h want 00", seg8, seg5); end
    checks++; if (addr8 !== 22'h0 || addr5 !== 19'h0) begin errors++; $display("FAIL reset_address got %h/%h want 0", addr8, addr5); end
    checks++; if (ack8 !== 1'b0 || en8 !== 1'b0 || rdata8 !== 8'h00) begin errors++; $display("FAIL reset_bus got ack=%b en=%b rd=%h want 0", ack8, en8, rdata8); end
    checks++; if (state8 !== MAPPER_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", state8); end
    reset_n = 1'b1;
    model_reset();
    for (int p = 0; p < 4; p++) begin
      bus_address = 16'(p) << 14;
      @(negedge clk);
      checks++; if (seg8 !== m8[p] || seg5 !== m5[p]) begin errors++; $display("FAIL init_lookup page %0d got %h/%h want %h/%h", p, seg8, seg5, m8[p], m5[p]); end
    end
    bus_address = 16'h4000;
    @(negedge clk);
    checks++; if (addr8 !== {8'h02, 14'h0000}) begin errors++; $display("FAIL init_address got %h want %h", addr8, {8'h02, 14'h0000}); end
  endtask

  task automatic check_lookups(input string tag);
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      bus_address = (16'(p) << 14) | 16'h0123;
      @(negedge clk);
      checks++; if (seg8 !== m8[p] || seg5 !== m5[p]) begin errors++; $display("FAIL %s page %0d got %h/%h want %h/%h", tag, p, seg8, seg5, m8[p], m5[p]); end
      checks++; if (addr8 !== {m8[p], 14'h0123}) begin errors++; $display("FAIL %s_addr page %0d got %h want %h", tag, p, addr8, {m8[p], 14'h0123}); end
    end
  endtask

  task automatic test_write_read();
    int ack_cnt, ack_at, en_cnt, en_at, ack5_cnt, rd_bad;
    logic [7:0] rd8, rd5, seg_after;
    logic [7:0] data [4];
    data = '{8'h12, 8'h23, 8'h34, 8'h45};
    for (int i = 0; i < 4; i++) begin
      io_access(16'h00FC + 16'(i), 1'b1, data[i], 1, ack_cnt, ack_at, en_cnt, en_at, rd8, rd5, ack5_cnt, seg_after, rd_bad);
      model_write(i, data[i]);
      checks++; if (ack_cnt != 1 || ack_at != 1) begin errors++; $display("FAIL write_ack port %0d got cnt=%0d at=%0d want 1/1", i, ack_cnt, ack_at); end
      checks++; if (seg_after !== m8[0]) begin errors++; $display("FAIL write_bypass port %0d got %h want %h", i, seg_after, m8[0]); end
    end
    for (int i = 0; i < 4; i++) begin
      io_access(16'h00FC + 16'(i), 1'b0, 8'h00, 1, ack_cnt, ack_at, en_cnt, en_at, rd8, rd5, ack5_cnt, seg_after, rd_bad);
      checks++; if (ack_cnt != 1 || ack_at != 1) begin errors++; $display("FAIL read_ack port %0d got cnt=%0d at=%0d want 1/1", i, ack_cnt, ack_at); end
      checks++; if (rd_bad != 0) begin errors++; $display("FAIL rdata_idle port %0d got %0d want 0", i, rd_bad); end
`ifdef MEMORY_MAPPER_READBACK_EN
      checks++; if (en_cnt != 1 || en_at != 2) begin errors++; $display("FAIL read_strobe port %0d got cnt=%0d at=%0d want 1/2", i, en_cnt, en_at); end
      checks++; if (rd8 !== m8[i] || rd5 !== (m5[i] | 8'hE0)) begin errors++; $display("FAIL read_data port %0d got %h/%h want %h/%h", i, rd8, rd5, m8[i], m5[i] | 8'hE0); end
`else
      checks++; if (en_cnt != 0) begin errors++; $display("FAIL writeonly_strobe port %0d got %0d want 0", i, en_cnt); end
`endif
    end
    check_lookups("after_writes");
  endtask

  task automatic test_no_decode();
    int ack_cnt, ack_at, en_cnt, en_at, ack5_cnt, rd_bad;
    logic [7:0] rd8, rd5, seg_after;
    logic [15:0] ports [5];
    ports = '{16'h001C, 16'h002D, 16'h003E, 16'h004F, 16'h005C};
    for (int i = 0; i < 5; i++) begin
      io_access(ports[i], 1'b1, 8'hA5, 1, ack_cnt, ack_at, en_cnt, en_at, rd8, rd5, ack5_cnt, seg_after, rd_bad);
      checks++; if (ack_cnt != 0 || ack5_cnt != 0 || en_cnt != 0) begin errors++; $display("FAIL no_decode port %h got ack=%0d/%0d en=%0d want 0", ports[i], ack_cnt, ack5_cnt, en_cnt); end
    end
    check_lookups("after_no_decode");
  endtask

  task automatic test_seg5();
    int ack_cnt, ack_at, en_cnt, en_at, ack5_cnt, rd_bad;
    logic [7:0] rd8, rd5, seg_after;
    io_access(16'h00FE, 1'b1, 8'hEF, 1, ack_cnt, ack_at, en_cnt, en_at, rd8, rd5, ack5_cnt, seg_after, rd_bad);
    model_write(2, 8'hEF);
    checks++; if (ack5_cnt != 1) begin errors++; $display("FAIL seg5_ack got %0d want 1", ack5_cnt); end
`ifdef MEMORY_MAPPER_READBACK_EN
    io_access(16'h00FE, 1'b0, 8'h00, 1, ack_cnt, ack_at, en_cnt, en_at, rd8, rd5, ack5_cnt, seg_after, rd_bad);
    checks++; if (rd5 !== 8'hEF || rd8 !== 8'hEF) begin errors++; $display("FAIL seg5_readback got %h/%h want EF/EF", rd5, rd8); end
`endif
    @(negedge clk);
    bus_address = 16'h8000;
    @(negedge clk);
    checks++; if (seg5 !== 8'h0F || seg8 !== 8'hEF) begin errors++; $display("FAIL seg5_lookup got %h/%h want 0F/EF", seg5, seg8); end
    checks++; if (addr5 !== {5'h0F, 14'h0000}) begin errors++; $display("FAIL seg5_address got %h want %h", addr5, {5'h0F, 14'h0000}); end
  endtask

  task automatic test_hold();
    int ack_cnt, ack_at, en_cnt, en_at, ack5_cnt, rd_bad;
    logic [7:0] rd8, rd5, seg_after, d;
    d = 8'($urandom_range(0, 255));
    io_access(16'h00FC, 1'b1, d, 8, ack_cnt, ack_at, en_cnt, en_at, rd8, rd5, ack5_cnt, seg_after, rd_bad);
    model_write(0, d);
    checks++; if (ack_cnt != 1 || ack5_cnt != 1) begin errors++; $display("FAIL hold_single_ack got %0d/%0d want 1", ack_cnt, ack5_cnt); end
    check_lookups("after_hold");
  endtask

  task automatic test_reset_mid();
    int acks, ens;
    acks = 0; ens = 0;
    @(negedge clk);
    bus_address = 16'h00FD; bus_wrt = 1'b0; bus_io_req = 1'b1;
    @(negedge clk);
    checks++; if (ack8 !== 1'b1) begin errors++; $display("FAIL mid_ack got %b want 1", ack8); end
    reset_n = 1'b0;
    @(negedge clk);
    if (en8 || en5) ens++;
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack8 || ack5) acks++;
      if (en8 || en5) ens++;
    end
    bus_io_req = 1'b0;
    model_reset();
    checks++; if (acks != 0 || ens != 0) begin errors++; $display("FAIL mid_reset_abort got ack=%0d en=%0d want 0/0", acks, ens); end
    check_lookups("after_mid_reset");
  endtask

  task automatic test_random();
    int ack_cnt, ack_at, en_cnt, en_at, ack5_cnt, rd_bad;
    logic [7:0] rd8, rd5, seg_after, port, d;
    logic [15:0] addr;
    logic hit, wrt;
    int page;
    for (int n = 0; n < 40; n++) begin
      hit = ($urandom_range(0, 3) != 0);
      if (hit) port = {6'h3F, 2'($urandom_range(0, 3))};
      else port = {6'($urandom_range(0, 62)), 2'($urandom_range(0, 3))};
      addr = {8'($urandom_range(0, 255)), port};
      wrt = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      page = int'(port[1:0]);
      io_access(addr, wrt, d, int'($urandom_range(1, 3)), ack_cnt, ack_at, en_cnt, en_at, rd8, rd5, ack5_cnt, seg_after, rd_bad);
      if (hit && wrt) model_write(page, d);
      checks++; if (ack_cnt != (hit ? 1 : 0) || ack5_cnt != (hit ? 1 : 0)) begin errors++; $display("FAIL rand_ack addr %h got %0d/%0d want %0d", addr, ack_cnt, ack5_cnt, hit); end
      checks++; if (seg_after !== m8[addr[15:14]]) begin errors++; $display("FAIL rand_lookup addr %h got %h want %h", addr, seg_after, m8[addr[15:14]]); end
      checks++; if (rd_bad != 0) begin errors++; $display("FAIL rand_rdata_idle addr %h got %0d want 0", addr, rd_bad); end
`ifdef MEMORY_MAPPER_READBACK_EN
      if (hit && !wrt) begin
        checks++; if (en_at != 2 || rd8 !== m8[page] || rd5 !== (m5[page] | 8'hE0)) begin errors++; $display("FAIL rand_read addr %h got at=%0d %h/%h want 2 %h/%h", addr, en_at, rd8, rd5, m8[page], m5[page] | 8'hE0); end
      end else begin
        checks++; if (en_cnt != 0) begin errors++; $display("FAIL rand_no_strobe addr %h got %0d want 0", addr, en_cnt); end
      end
`else
      checks++; if (en_cnt != 0) begin errors++; $display("FAIL rand_no_strobe addr %h got %0d want 0", addr, en_cnt); end
`endif
    end
    check_lookups("after_random");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_no_decode();
    test_seg5();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_mapper_core.md
# memory_mapper_core

Parametrised MSX memory mapper. It decodes the four mapper I/O ports (default FCh–FFh) on the internal I/O bus and holds one segment register per 16 KB page. It produces the registered segment number and the extended physical address for the CPU page currently on `bus_address`. It sits between the I/O bus arbiter and the RAM/SDRAM address path, and supports a configurable segment width and a configurable I/O base.

## Interface
- `SEG_BITS`, 8: implemented segment register width (1–8).
- `IO_BASE`, 8'hFC: first mapper port. Bits [1:0] must be 0.
- `clk`  in  1: system clock.
- `reset_n`  in  1: reset, synchronous, active-low. Single clock domain.
- `bus_io_req`  in  1: I/O request. Held high until `bus_ack`.
- `bus_ack`  out  1: one-cycle acknowledge for a decoded port.
- `bus_wrt`  in  1: 1 = write, 0 = read. Sampled with `bus_io_req`.
- `bus_address`  in  16: I/O port in [7:0]; CPU memory address for page lookup.
- `bus_wdata`  in  8: write data.
- `bus_rdata`  out  8: read data. Valid only while `bus_rdata_en` is high.
- `bus_rdata_en`  out  1: one-cycle read-data strobe.
- `mapper_segment`  out  8: segment for page `bus_address[15:14]`. Bits above `SEG_BITS` are 0.
- `mapper_address`  out  SEG_BITS+14: `{segment, bus_address[13:0]}`.

## Operation
- Decode: the port hits when `bus_address[7:2] == IO_BASE[7:2]`. `bus_address[15:8]` is ignored. Page index = `bus_address[1:0]`.
- Non-decoded requests get no ack and no `rdata_en`, and registers are unchanged.
- FSM states: IDLE, ACK, RDATA, RELEASE.
  - IDLE → ACK on `bus_io_req` & hit. Page index, `bus_wrt` and `bus_wdata` are captured in this cycle.
  - ACK: `bus_ack`=1. A write updates `seg[page] <= wdata[SEG_BITS-1:0]` in this cycle. Then go to RDATA for a read, or to RELEASE for a write.
  - RDATA: `bus_rdata_en`=1 and `bus_rdata` holds the readback value. Then go to RELEASE.
  - RELEASE: wait for `bus_io_req`=0, then go to IDLE. A request held high is never accepted twice.
- Readback value = `{(8-SEG_BITS){1'b1}, seg[page]}`. Unimplemented upper bits read as 1, matching real mapper RAM size detection.
- `bus_rdata` is 8'h00 whenever `bus_rdata_en`=0.
- Segment lookup is registered: `mapper_segment` and `mapper_address` reflect `bus_address` from the previous cycle. A write in ACK is visible in the lookup output from the next cycle.

## Timing
- Reset (`reset_n`=0 at a rising edge) sets:
  - `seg[0..3]` = 3, 2, 1, 0, truncated to `SEG_BITS`.
  - FSM = IDLE.
  - `bus_ack`, `bus_rdata_en`, `bus_rdata` = 0.
  - `mapper_segment` = 0 and `mapper_address` = 0.
- Reset mid-transaction aborts it. No ack or strobe is issued afterwards, even if `bus_io_req` stays high.
- Write latency: request sampled at edge N; `bus_ack` high in N+1.
- Read latency: `bus_ack` high in N+1; `bus_rdata_en` high in N+2. The read returns the register value as of cycle N+1.
- Minimum request spacing is 3 cycles for a write and 4 for a read, because `bus_io_req` must be seen low once.
- Page-lookup latency is 1 cycle. Lookup runs every cycle, including during I/O transactions.

## Configuration
- `MEMORY_MAPPER_READBACK_EN` defined: reads behave as described above.
- Not defined (write-only mapper):
  - Reads are still acked.
  - RDATA is skipped and `bus_rdata_en` never asserts.
  - Readback logic is removed.

## Structure
- Package `memory_mapper_pkg` holds:
  - the FSM state enum `mapper_state_t`;
  - `MAPPER_PAGES` = 4;
  - the reset segment constants `MAPPER_INIT_SEG[0:3]`.
- Sub-module `memory_mapper_regs`: the 4 × `SEG_BITS` register file with one write port and two read ports (I/O readback and page lookup). The top level contains the decode, FSM and lookup registers.

## Test plan
- Reset, then check `mapper_segment` with `bus_address` = 0000h / 4000h / 8000h / C000h → 03h, 02h, 01h, 00h. Check `mapper_address` for 4000h → `{02h, 0000h}`.
- Write FCh = 12h, FDh = 23h, FEh = 34h, FFh = 45h, then read each back → 12h, 23h, 34h, 45h. `bus_ack` is exactly one cycle after the request; `bus_rdata_en` is exactly one cycle after `bus_ack`.
- Access ports 1Ch, 2Dh, 3Eh, 4Fh, 5Ch (write A5h) → no `bus_ack`, and FCh–FFh still read 12h, 23h, 34h, 45h.
- With `SEG_BITS` = 5, write FEh = EFh → read gives EFh (bits [7:5] read as 1s), and `mapper_segment` for 8000h = 0Fh.
- Hold `bus_io_req` high for 8 cycles on a write to FCh → exactly one `bus_ack`. Pull `reset_n` low during ACK → no `bus_rdata_en`, and segments return to 03h, 02h, 01h, 00h.
- Build without `MEMORY_MAPPER_READBACK_EN` → a read of FCh is acked and `bus_rdata_en` stays 0 for 10 cycles.
